// File: rtl/rv_rr_arbiter.sv
// rv_rr_arbiter: round-robin arbiter that shares one ready/valid word channel
// among NUM_REQ requesters. It accepts one word from the winning requester and
// latches it. It offers the word downstream until the word is accepted, then
// pulses tx_done for one cycle, tagged with the requester ID.
//
// Optional build feature: define ARB_TIMEOUT_EN to add an OFFER-state watchdog.
// The watchdog drops a word that has waited TIMEOUT_CYC cycles and pulses
// timeout_err. Without the macro the arbiter waits indefinitely and
// timeout_err is tied to 0.
//
// Handshake semantics (both sides): a word moves on a rising clk edge exactly
// when valid && ready are both high in the cycle before that edge. Upstream,
// req_ready is a combinational one-hot pulse in IDLE, so req_valid[i] &&
// req_ready[i] means the word has been consumed. Downstream, out_valid stays
// high and out_data/out_id stay stable until out_ready is seen. The only
// exception is the optional watchdog drop.
module rv_rr_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int DATA_W      = 64,
  parameter int ID_W        = $clog2(NUM_REQ),
  parameter int TIMEOUT_CYC = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DATA_W-1:0]         out_data,
  output logic [ID_W-1:0]           out_id,
  output logic                      tx_done,
  output logic [ID_W-1:0]           done_id,
  output logic                      timeout_err,
  output logic [1:0]                dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_OFFER = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  // The pointer starts at the last requester, so requester 0 wins first.
  localparam logic [ID_W-1:0] PTR_RST = ID_W'(NUM_REQ - 1);

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYC < 2) begin : g_bad_param
    $error("rv_rr_arbiter: parameter out of range");
  end

  state_e              state_q, state_d;
  logic [ID_W-1:0]     last_grant_q, last_grant_d;
  logic [DATA_W-1:0]   out_data_q, out_data_d;
  logic [ID_W-1:0]     out_id_q, out_id_d;
  logic [ID_W-1:0]     done_id_q, done_id_d;

  logic                any_req;
  logic                hi_any;
  logic [ID_W-1:0]     lo_win;
  logic [ID_W-1:0]     hi_win;
  logic [ID_W-1:0]     winner;
  logic [DATA_W-1:0]   win_data;

  logic                grant;
  logic                accept;
  logic                tmo_fire;

  // Round-robin pick. The lowest requester above the pointer wins.
  // Otherwise the search wraps to the lowest requester overall.
  always_comb begin
    any_req = 1'b0;
    hi_any  = 1'b0;
    lo_win  = '0;
    hi_win  = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        any_req = 1'b1;
        lo_win  = ID_W'(i);
      end
      if (req_valid[i] && (ID_W'(i) > last_grant_q)) begin
        hi_any = 1'b1;
        hi_win = ID_W'(i);
      end
    end
    winner = hi_any ? hi_win : lo_win;
  end

  // Select the winner's data slice; other requesters' data is never sampled.
  always_comb begin
    win_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (ID_W'(i) == winner) begin
        win_data = req_data[i*DATA_W +: DATA_W];
      end
    end
  end

`ifdef ARB_TIMEOUT_EN
  localparam int              CNT_W    = $clog2(TIMEOUT_CYC) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic             timeout_err_q;

  // Watchdog fires on the last permitted stall cycle; acceptance wins over it.
  assign tmo_fire = (state_q == ST_OFFER) && !out_ready && (tmo_cnt_q == CNT_LAST);

  // Stall counter clears on each grant and counts OFFER cycles without ready.
  always_comb begin
    tmo_cnt_d = tmo_cnt_q;
    if (grant) begin
      tmo_cnt_d = '0;
    end else if ((state_q == ST_OFFER) && !out_ready && !tmo_fire) begin
      tmo_cnt_d = tmo_cnt_q + 1'b1;
    end
  end

  // Watchdog counter and one-cycle error pulse registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tmo_cnt_q     <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      tmo_cnt_q     <= tmo_cnt_d;
      timeout_err_q <= tmo_fire;
    end
  end

  assign timeout_err = timeout_err_q;
`else
  assign tmo_fire    = 1'b0;
  assign timeout_err = 1'b0;
`endif

  // FSM next state and the combinational upstream accept pulse.
  always_comb begin
    state_d   = state_q;
    req_ready = '0;
    grant     = 1'b0;
    accept    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (any_req && !reset) begin
          grant     = 1'b1;
          req_ready = NUM_REQ'(1) << winner;
          state_d   = ST_OFFER;
        end
      end
      ST_OFFER: begin
        if (out_ready) begin
          accept  = 1'b1;
          state_d = ST_DONE;
        end else if (tmo_fire) begin
          state_d = ST_IDLE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Datapath next values: latch on grant, record ID on completion or drop.
  always_comb begin
    last_grant_d = last_grant_q;
    out_data_d   = out_data_q;
    out_id_d     = out_id_q;
    done_id_d    = done_id_q;
    if (grant) begin
      last_grant_d = winner;
      out_data_d   = win_data;
      out_id_d     = winner;
    end
    if (accept || tmo_fire) begin
      done_id_d = out_id_q;
    end
  end

  // State, pointer and latched-word registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      last_grant_q <= PTR_RST;
      out_data_q   <= '0;
      out_id_q     <= '0;
      done_id_q    <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      out_data_q   <= out_data_d;
      out_id_q     <= out_id_d;
      done_id_q    <= done_id_d;
    end
  end

  assign out_valid = (state_q == ST_OFFER);
  assign tx_done   = (state_q == ST_DONE);
  assign out_data  = out_data_q;
  assign out_id    = out_id_q;
  assign done_id   = done_id_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_rv_rr_arbiter.sv
// tb_rv_rr_arbiter: bench for rv_rr_arbiter (NUM_REQ=4, DATA_W=64).
// It runs a vector table, hand sequences for the multi-cycle corners, and a
// randomized phase checked against a transaction-level reference model.
module tb_rv_rr_arbiter;
  localparam int NR  = 4;
  localparam int DW  = 64;
  localparam int IW  = 2;
  localparam int TMO = 16;

  logic             clk = 1'b0;
  logic             reset;
  logic [NR-1:0]    req_valid;
  logic [NR*DW-1:0] req_data;
  logic [NR-1:0]    req_ready;
  logic             out_valid;
  logic             out_ready;
  logic [DW-1:0]    out_data;
  logic [IW-1:0]    out_id;
  logic             tx_done;
  logic [IW-1:0]    done_id;
  logic             timeout_err;
  logic [1:0]       dbg_state;

  int total = 0;
  int bad   = 0;

  // Scoreboard: expected {id, word} in grant order.
  logic [IW+DW-1:0] exp_q[$];
  int               m_ptr;
  bit               m_busy;
  bit               m_done_now;
  logic [IW-1:0]    m_done_id;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  rv_rr_arbiter #(
    .NUM_REQ(NR), .DATA_W(DW), .ID_W(IW), .TIMEOUT_CYC(TMO)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_id(out_id),
    .tx_done(tx_done), .done_id(done_id),
    .timeout_err(timeout_err), .dbg_state(dbg_state)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: got=no_finish want=finish");
    $fatal(1, "time limit");
  end

  // ---------------- helpers ----------------
  function automatic logic [DW-1:0] slot(input int i);
    return {32'hDEAD_BEEF, 32'(i + 1)};
  endfunction

  task automatic set_slots();
    for (int i = 0; i < NR; i++) req_data[i*DW +: DW] = slot(i);
  endtask

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", nm, act, exp);
    end
  endtask

  // Reference winner: first valid requester after the pointer, modulo NR.
  function automatic int model_winner(input logic [NR-1:0] rv, input int ptr);
    int idx;
    for (int d = 1; d <= NR; d++) begin
      idx = (ptr + d) % NR;
      if (rv[idx[IW-1:0]]) return idx;
    end
    return -1;
  endfunction

  // ---------------- driver tasks ----------------
  // One full grant / offer / done transaction with out_ready held high.
  task automatic do_grant(input logic [NR-1:0] rv, input int id, input string nm);
    req_valid = rv; out_ready = 1'b1;
    @(negedge clk);
    chk({nm, "_rr"}, req_ready, NR'(1) << id);
    chk({nm, "_td0"}, tx_done, 0);
    @(posedge clk); #1;
    req_valid = '0;
    @(negedge clk);
    chk({nm, "_ov"}, out_valid, 1);
    chk({nm, "_oid"}, out_id, id);
    chk({nm, "_odata"}, out_data, slot(id));
    @(posedge clk); #1;
    @(negedge clk);
    chk({nm, "_td"}, tx_done, 1);
    chk({nm, "_did"}, done_id, id);
    chk({nm, "_ov0"}, out_valid, 0);
    @(posedge clk); #1;
  endtask

  // One random-phase cycle, checked against the transaction model.
  task automatic model_cycle(input logic [NR-1:0] rv, input logic ordy);
    int w;
    logic [IW+DW-1:0] head;
    req_valid = rv; out_ready = ordy;
    @(negedge clk);
    chk("rnd_te", timeout_err, 0);
    if (m_done_now) begin
      chk("rnd_td", tx_done, 1);
      chk("rnd_did", done_id, m_done_id);
      chk("rnd_ov_done", out_valid, 0);
      chk("rnd_rr_done", req_ready, 0);
      m_busy = 1'b0;
      m_done_now = 1'b0;
    end else if (m_busy) begin
      head = (exp_q.size() > 0) ? exp_q[0] : '0;
      chk("rnd_ov", out_valid, 1);
      chk("rnd_rr_busy", req_ready, 0);
      chk("rnd_td_busy", tx_done, 0);
      chk("rnd_word", {out_id, out_data}, head);
      if (ordy) begin
        m_done_id = head[IW+DW-1:DW];
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        m_done_now = 1'b1;
      end
    end else begin
      chk("rnd_ov_idle", out_valid, 0);
      chk("rnd_td_idle", tx_done, 0);
      w = model_winner(rv, m_ptr);
      if (w < 0) begin
        chk("rnd_rr_none", req_ready, 0);
      end else begin
        chk("rnd_rr", req_ready, NR'(1) << w);
        exp_q.push_back({IW'(w), req_data[w*DW +: DW]});
        m_ptr = w;
        m_busy = 1'b1;
      end
    end
    @(posedge clk); #1;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [NR-1:0] rv;
    logic          ordy;
    logic [NR-1:0] rr;
    logic          ov;
    logic [IW-1:0] oid;
    logic [DW-1:0] odata;
    logic          td;
    logic [IW-1:0] did;
  } vec_t;

  vec_t tbl[18];

  initial begin
    int stall;

    // Single request, then all four held: grants 0,1,2,3,0,1, one per 3 cycles.
    tbl[0]  = '{4'b0001, 1'b1, 4'b0001, 1'b0, 2'd0, 64'h0,    1'b0, 2'd0};
    tbl[1]  = '{4'b0000, 1'b1, 4'b0000, 1'b1, 2'd0, slot(0), 1'b0, 2'd0};
    tbl[2]  = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, slot(0), 1'b1, 2'd0};
    tbl[3]  = '{4'b1111, 1'b1, 4'b0010, 1'b0, 2'd0, slot(0), 1'b0, 2'd0};
    tbl[4]  = '{4'b1111, 1'b1, 4'b0000, 1'b1, 2'd1, slot(1), 1'b0, 2'd0};
    tbl[5]  = '{4'b1111, 1'b1, 4'b0000, 1'b0, 2'd1, slot(1), 1'b1, 2'd1};
    tbl[6]  = '{4'b1111, 1'b1, 4'b0100, 1'b0, 2'd1, slot(1), 1'b0, 2'd1};
    tbl[7]  = '{4'b1111, 1'b1, 4'b0000, 1'b1, 2'd2, slot(2), 1'b0, 2'd1};
    tbl[8]  = '{4'b1111, 1'b1, 4'b0000, 1'b0, 2'd2, slot(2), 1'b1, 2'd2};
    tbl[9]  = '{4'b1111, 1'b1, 4'b1000, 1'b0, 2'd2, slot(2), 1'b0, 2'd2};
    tbl[10] = '{4'b1111, 1'b1, 4'b0000, 1'b1, 2'd3, slot(3), 1'b0, 2'd2};
    tbl[11] = '{4'b1111, 1'b1, 4'b0000, 1'b0, 2'd3, slot(3), 1'b1, 2'd3};
    tbl[12] = '{4'b1111, 1'b1, 4'b0001, 1'b0, 2'd3, slot(3), 1'b0, 2'd3};
    tbl[13] = '{4'b1111, 1'b1, 4'b0000, 1'b1, 2'd0, slot(0), 1'b0, 2'd3};
    tbl[14] = '{4'b1111, 1'b1, 4'b0000, 1'b0, 2'd0, slot(0), 1'b1, 2'd0};
    tbl[15] = '{4'b1111, 1'b1, 4'b0010, 1'b0, 2'd0, slot(0), 1'b0, 2'd0};
    tbl[16] = '{4'b1111, 1'b1, 4'b0000, 1'b1, 2'd1, slot(1), 1'b0, 2'd0};
    tbl[17] = '{4'b1111, 1'b1, 4'b0000, 1'b0, 2'd1, slot(1), 1'b1, 2'd1};

    // Reset state, with requests and ready asserted to show they are masked.
    reset = 1'b1; req_valid = 4'b1111; out_ready = 1'b1; req_data = '0; set_slots();
    @(negedge clk);
    chk("rst_rr", req_ready, 0);
    chk("rst_ov", out_valid, 0);
    chk("rst_td", tx_done, 0);
    chk("rst_te", timeout_err, 0);
    chk("rst_odata", out_data, 0);
    chk("rst_oid", out_id, 0);
    chk("rst_did", done_id, 0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    for (int r = 0; r < 18; r++) begin
      req_valid = tbl[r].rv; out_ready = tbl[r].ordy;
      @(negedge clk);
      chk($sformatf("vec%0d_rr", r), req_ready, tbl[r].rr);
      chk($sformatf("vec%0d_ov", r), out_valid, tbl[r].ov);
      chk($sformatf("vec%0d_oid", r), out_id, tbl[r].oid);
      chk($sformatf("vec%0d_odata", r), out_data, tbl[r].odata);
      chk($sformatf("vec%0d_td", r), tx_done, tbl[r].td);
      chk($sformatf("vec%0d_did", r), done_id, tbl[r].did);
      chk($sformatf("vec%0d_te", r), timeout_err, 0);
      @(posedge clk); #1;
    end

    // Stall: requester 2 offered for 6 cycles; input churn during the wait is ignored.
    req_valid = 4'b0100; out_ready = 1'b0;
    @(negedge clk);
    chk("stall_rr", req_ready, 4'b0100);
    @(posedge clk); #1;
    for (int k = 0; k < 6; k++) begin
      req_valid = 4'($urandom_range(0, 15));
      for (int i = 0; i < NR; i++) req_data[i*DW +: DW] = {$urandom, $urandom};
      out_ready = (k == 5);
      @(negedge clk);
      chk("stall_ov", out_valid, 1);
      chk("stall_odata", out_data, slot(2));
      chk("stall_oid", out_id, 2);
      chk("stall_rr0", req_ready, 0);
      chk("stall_td0", tx_done, 0);
      @(posedge clk); #1;
    end
    req_valid = '0; out_ready = 1'b1; set_slots();
    @(negedge clk);
    chk("stall_td", tx_done, 1);
    chk("stall_did", done_id, 2);
    chk("stall_ov0", out_valid, 0);
    @(posedge clk); #1;

    // Wrap-around: pointer at 1 after the first grant, then 0011 picks 0.
    do_grant(4'b0010, 1, "wrap_a");
    do_grant(4'b0011, 0, "wrap_b");
    do_grant(4'b0010, 1, "wrap_c");

    // Asynchronous reset during OFFER drops the word and rewinds the pointer.
    req_valid = 4'b0100; out_ready = 1'b0;
    @(negedge clk);
    chk("rmid_rr", req_ready, 4'b0100);
    @(posedge clk); #1;
    req_valid = '0;
    #1;
    chk("rmid_ov1", out_valid, 1);
    reset = 1'b1;
    #1;
    chk("rmid_ov0", out_valid, 0);
    chk("rmid_odata", out_data, 0);
    chk("rmid_oid", out_id, 0);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("rmid_td", tx_done, 0);
    chk("rmid_ov_after", out_valid, 0);
    @(posedge clk); #1;
    do_grant(4'b1001, 0, "rmid_next");

    // Randomized phase against the reference model.
    m_ptr = 0; m_busy = 1'b0; m_done_now = 1'b0; exp_q.delete();
    stall = 0;
    for (int c = 0; c < 300; c++) begin
      logic ordy;
      for (int i = 0; i < NR; i++) req_data[i*DW +: DW] = {$urandom, $urandom};
      ordy = (stall >= 8) ? 1'b1 : 1'($urandom_range(0, 1));
      stall = ordy ? 0 : stall + 1;
      model_cycle(4'($urandom_range(0, 15)), ordy);
    end
    for (int k = 0; k < 6 && (m_busy || m_done_now); k++) model_cycle('0, 1'b1);
    chk("rnd_drained", {m_busy, m_done_now}, 0);
    set_slots();

`ifdef ARB_TIMEOUT_EN
    // Watchdog drop after 16 stalled OFFER cycles.
    req_valid = 4'b0100; out_ready = 1'b0;
    @(negedge clk);
    chk("tmo_rr", req_ready, 4'b0100);
    @(posedge clk); #1;
    req_valid = '0;
    for (int k = 0; k < TMO; k++) begin
      @(negedge clk);
      chk("tmo_ov", out_valid, 1);
      chk("tmo_te0", timeout_err, 0);
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk("tmo_te", timeout_err, 1);
    chk("tmo_did", done_id, 2);
    chk("tmo_td0", tx_done, 0);
    chk("tmo_ov0", out_valid, 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("tmo_te_pulse", timeout_err, 0);
    @(posedge clk); #1;
    do_grant(4'b1111, 3, "tmo_next");
    // Acceptance on the final OFFER cycle wins over the watchdog.
    req_valid = 4'b0100; out_ready = 1'b0;
    @(negedge clk);
    chk("tacc_rr", req_ready, 4'b0100);
    @(posedge clk); #1;
    req_valid = '0;
    for (int k = 0; k < TMO; k++) begin
      out_ready = (k == TMO - 1);
      @(negedge clk);
      chk("tacc_ov", out_valid, 1);
      chk("tacc_te0", timeout_err, 0);
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk("tacc_td", tx_done, 1);
    chk("tacc_did", done_id, 2);
    chk("tacc_te", timeout_err, 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("tacc_te_after", timeout_err, 0);
    @(posedge clk); #1;
`else
    // Without the watchdog the word is held indefinitely.
    req_valid = 4'b0100; out_ready = 1'b0;
    @(negedge clk);
    chk("long_rr", req_ready, 4'b0100);
    @(posedge clk); #1;
    req_valid = '0;
    for (int k = 0; k < 24; k++) begin
      @(negedge clk);
      chk("long_ov", out_valid, 1);
      chk("long_odata", out_data, slot(2));
      chk("long_te", timeout_err, 0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("long_ov_last", out_valid, 1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("long_td", tx_done, 1);
    chk("long_did", done_id, 2);
    @(posedge clk); #1;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
